// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, signed or unsigned, one quotient bit per clock.
// result_o packs {remainder, quotient}; a zero divisor completes early with an all-zero result.
module seq_divider #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [2*DATA_W:0]     r_work;
    logic [DATA_W-1:0]     r_div;
    logic                  r_sq;
    logic                  r_sr;
    logic [2*DATA_W-1:0]   r_result;
    logic                  r_ready;

    logic                  w_neg1;
    logic                  w_neg2;
    logic [DATA_W-1:0]     w_mag1;
    logic [DATA_W-1:0]     w_mag2;
    logic [DATA_W:0]       w_diff;
    logic [DATA_W-1:0]     w_quo;
    logic [DATA_W-1:0]     w_rem;

    assign w_neg1 = signed_div_i & opdata1_i[DATA_W-1];
    assign w_neg2 = signed_div_i & opdata2_i[DATA_W-1];
    assign w_mag1 = w_neg1 ? -opdata1_i : opdata1_i;
    assign w_mag2 = w_neg2 ? -opdata2_i : opdata2_i;
    // Trial subtraction of the divisor from the partial remainder; MSB set means it did not fit.
    assign w_diff = {1'b0, r_work[2*DATA_W-1:DATA_W]} - {1'b0, r_div};
    assign w_quo  = r_work[DATA_W-1:0];
    assign w_rem  = r_work[2*DATA_W:DATA_W+1];

    assign result_o = r_result;
    assign ready_o  = r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_work   <= '0;
            r_div    <= '0;
            r_sq     <= 1'b0;
            r_sr     <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        r_sq    <= w_neg1 ^ w_neg2;
                        r_sr    <= w_neg1;
                        r_div   <= w_mag2;
                        r_work  <= {{DATA_W{1'b0}}, w_mag1, 1'b0};
                        r_cnt   <= '0;
                        r_state <= (opdata2_i == '0) ? S_DIVZERO : S_ON;
                    end
                end
                S_DIVZERO: begin
                    if (annul_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= '0;
                        r_ready  <= 1'b1;
                        r_state  <= S_END;
                    end
                end
                S_ON: begin
                    if (annul_i || !start_i) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != LAST) begin
                        r_work <= w_diff[DATA_W] ? {r_work[2*DATA_W-1:0], 1'b0}
                                                 : {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
                        r_cnt  <= r_cnt + CW'(1);
                    end else begin
                        r_result <= {r_sr ? -w_rem : w_rem, r_sq ? -w_quo : w_quo};
                        r_ready  <= 1'b1;
                        r_state  <= S_END;
                    end
                end
                S_END: begin
                    if (annul_i || !start_i) begin
                        r_ready <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdiv = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] last_exp = '0;

    seq_divider #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(sdiv), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
    );

    always #5 clk = ~clk;

    // Reference: language-level division; signed truncates toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint q, r;
        if (b == 0) return 64'h0;
        if (s) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int hold, input string name);
        logic [63:0] exp;
        int lat, exp_lat;
        exp = ref_div(a, b, s);
        exp_lat = (b == 0) ? 1 : 33;
        op1 = a; op2 = b; sdiv = s; start = 1'b1;
        lat = -1;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                op1 = $urandom; op2 = $urandom; sdiv = 1'($urandom);
            end
            if (ready) begin
                lat = e;
                break;
            end
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (result !== exp) begin
            n_errors++;
            $display("FAIL %s result: got %h expected %h (a=%h b=%h s=%0d)", name, result, exp, a, b, s);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ready !== 1'b1 || result !== exp) begin
                n_errors++;
                $display("FAIL %s hold: got ready=%b result=%h expected ready=1 result=%h", name, ready, result, exp);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b0 || result !== exp) begin
            n_errors++;
            $display("FAIL %s release: got ready=%b result=%h expected ready=0 result=%h", name, ready, result, exp);
        end
        last_exp = exp;
    endtask

    task automatic expect_quiet(input int cycles, input string name);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ready !== 1'b0 || result !== last_exp) begin
                n_errors++;
                $display("FAIL %s quiet: got ready=%b result=%h expected ready=0 result=%h", name, ready, result, last_exp);
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_errors++;
            $display("FAIL reset: got ready=%b result=%h expected ready=0 result=0", ready, result);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_exp = 64'h0;
        expect_quiet(3, "reset_idle");
    endtask

    task automatic test_directed();
        run_div(32'd100, 32'd7, 1'b0, 0, "u100_7");
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, "s_m7_2");
        run_div(32'hFFFFFFF9, 32'd2, 1'b0, 0, "u_m7_2");
        run_div(32'd5, 32'd0, 1'b0, 0, "divzero");
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, "s_overflow");
        run_div(32'h80000000, 32'd0, 1'b1, 0, "s_divzero");
        run_div(32'd3, 32'd9, 1'b0, 0, "small_by_big");
    endtask

    task automatic test_back_to_back();
        run_div(32'd123456, 32'd789, 1'b0, 5, "hold_end");
        run_div(32'hFFFF0000, 32'hFFFFFFF0, 1'b1, 0, "after_hold");
        run_div(32'd0, 32'd0, 1'b0, 3, "hold_divzero");
    endtask

    task automatic test_annul();
        run_div(32'd1000, 32'd3, 1'b0, 0, "pre_annul");
        op1 = 32'd777; op2 = 32'd5; sdiv = 1'b0; start = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (e == 9) annul = 1'b1;
        end
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        expect_quiet(40, "annul_on");
        run_div(32'd9, 32'd3, 1'b0, 0, "after_annul");
        // Annul in IDLE must block acceptance even with start held.
        op1 = 32'd50; op2 = 32'd5; start = 1'b1; annul = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        annul = 1'b0;
        run_div(32'd50, 32'd5, 1'b0, 0, "annul_idle");
        op1 = 32'd5; op2 = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL annul_divzero: got ready=%b expected 0", ready);
        end
        expect_quiet(5, "annul_divzero");
    endtask

    task automatic test_async_reset();
        run_div(32'd98765, 32'd43, 1'b0, 0, "pre_reset");
        op1 = 32'd12345; op2 = 32'd67; sdiv = 1'b0; start = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            @(posedge clk); #1;
        end
        #3 rst = 1'b1;
        start = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_errors++;
            $display("FAIL async_reset: got ready=%b result=%h expected ready=0 result=0", ready, result);
        end
        #2 rst = 1'b0;
        last_exp = 64'h0;
        expect_quiet(40, "post_reset");
        run_div(32'd12345, 32'd67, 1'b0, 0, "fresh_after_reset");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            run_div(a, b, 1'($urandom), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_annul();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
